// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: successive-approximation search controller for a 10-bit
// external comparator. Each step presents trial = r | ((1<<i)-1), so gt_in
// tells whether the target is at least r | (1<<i); the bit is kept when it is.
// Optional build macro: SAR_SETTLE_EN adds a comparator settle cycle per step
// (trial held two cycles, gt_in sampled on the second edge).
module sar_search_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       gt_in,
    output logic [9:0] trial,
    output logic       busy,
    output logic       done,
    output logic [9:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] idx;
    logic [9:0] acc;
    logic [9:0] bitmask;
    logic [9:0] accnext;
    logic [9:0] masknext;
    logic       stepend;

`ifdef SAR_SETTLE_EN
    logic       settle;
`endif

    // Next accumulator value and the lower-bit mask for the following step
    always_comb begin
        bitmask  = 10'd1 << idx;
        accnext  = gt_in ? (acc | bitmask) : acc;
        masknext = (bitmask >> 1) - 10'd1;
`ifdef SAR_SETTLE_EN
        stepend  = settle;
`else
        stepend  = 1'b1;
`endif
    end

    // Search FSM with registered outputs; a step only resolves on stepend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= 4'd9;
            acc    <= 10'd0;
            trial  <= 10'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 10'd0;
`ifdef SAR_SETTLE_EN
            settle <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= CONVERT;
                        idx    <= 4'd9;
                        acc    <= 10'd0;
                        trial  <= 10'h1FF;
                        busy   <= 1'b1;
`ifdef SAR_SETTLE_EN
                        settle <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                        trial <= 10'd0;
                        busy  <= 1'b0;
                    end
                end
                CONVERT: begin
`ifdef SAR_SETTLE_EN
                    settle <= ~settle;
`endif
                    if (stepend) begin
                        acc <= accnext;
                        if (idx == 4'd0) begin
                            result <= accnext;
                            state  <= DONE;
                            trial  <= 10'd0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            idx   <= idx - 4'd1;
                            trial <= accnext | masknext;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    trial <= 10'd0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: directed bench for sar_search_ctrl with a comparator
// model, a per-cycle trial/busy reference and a result scoreboard.
// Honours SAR_SETTLE_EN (each trial held for two cycles).
module tb_sar_search_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       gt_in;
    logic [9:0] trial;
    logic       busy;
    logic       done;
    logic [9:0] result;
    logic [9:0] aval;

    int         checks = 0;
    int         fails  = 0;
    logic [9:0] sbqueue[$];

`ifdef SAR_SETTLE_EN
    localparam int HOLDS = 2;
`else
    localparam int HOLDS = 1;
`endif

    sar_search_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .gt_in  (gt_in),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // External comparator: target value versus presented trial
    assign gt_in = (aval > trial);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a start request for target a and record the expected result
    task automatic applyStimulus(input logic [9:0] a);
        @(negedge clk);
        aval  = a;
        start = 1'b1;
        sbqueue.push_back(a);
    endtask

    // Follow one conversion cycle by cycle; start is dropped unless held
    task automatic trackConversion(input bit holdstart);
        logic [9:0] r;
        logic [9:0] exptrial;
        logic [9:0] expres;
        r = 10'd0;
        for (int i = 9; i >= 0; i--) begin
            exptrial = r | 10'((1 << i) - 1);
            for (int h = 0; h < HOLDS; h++) begin
                @(negedge clk);
                if (!holdstart) start = 1'b0;
                checkOutput("busy_in_convert", busy, 1);
                checkOutput("trial_step", trial, exptrial);
                checkOutput("done_in_convert", done, 0);
            end
            if (aval > exptrial) r[i] = 1'b1;
        end
        @(negedge clk);
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_in_done", busy, 0);
        checkOutput("trial_in_done", trial, 0);
        expres = (sbqueue.size() > 0) ? sbqueue.pop_front() : 10'bx;
        checkOutput("result", result, expres);
    endtask

    initial begin
        logic sawdone;
        rst_n = 1'b0;
        start = 1'b0;
        aval  = 10'd0;

        // Reset state
        #12;
        checkOutput("reset_trial", trial, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Target zero: trial walks 1FF down to 000
        applyStimulus(10'd0);
        trackConversion(1'b0);
        @(negedge clk);
        checkOutput("done_single_cycle", done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_trial", trial, 0);

        // Full scale: every comparison high, last trial 3FE
        applyStimulus(10'd1023);
        trackConversion(1'b0);

        // Mid pattern, then result must hold through idle
        applyStimulus(10'd600);
        trackConversion(1'b0);
        @(negedge clk);
        checkOutput("done_drop_600", done, 0);
        repeat (3) @(negedge clk);
        checkOutput("result_hold_idle", result, 600);

        // Back-to-back conversions with start held high throughout
        applyStimulus(10'd5);
        for (int n = 0; n < 3; n++) begin
            trackConversion(1'b1);
            if (n < 2) sbqueue.push_back(10'd5);
            else start = 1'b0;
        end
        @(negedge clk);
        checkOutput("b2b_return_idle", busy, 0);

        // Asynchronous reset in the middle of the i=4 step
        applyStimulus(10'd777);
        for (int n = 0; n < 5 * HOLDS + 1; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("pre_reset_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_trial", trial, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_done", done, 0);
        checkOutput("async_result", result, 0);
        sbqueue.delete();
        @(negedge clk);
        rst_n = 1'b1;
        sawdone = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done) sawdone = 1'b1;
        end
        checkOutput("no_done_after_reset", sawdone, 0);
        applyStimulus(10'd777);
        trackConversion(1'b0);

        // Value used for the settle-cycle build, plus a few random targets
        applyStimulus(10'd321);
        trackConversion(1'b0);
        for (int n = 0; n < 4; n++) begin
            applyStimulus(10'($urandom_range(0, 1023)));
            trackConversion(1'b0);
        end
        @(negedge clk);
        checkOutput("final_idle_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
